rf_writeback_arbiter: RTL and testbench
=======================================

// Module: rf_writeback_arbiter
// PURPOSE
//  Write-side master for the 32x32 register file. Collects results from the
//  ALU and load/store paths and serializes them onto the single RF write port.
//  The write port is rf_we/rf_addr/rf_wdata; the RF write address is its addr0.
//  Keeps a pending-write scoreboard that decode uses to stall on RAW hazards.
// PARAMETERS
//  DATA_W     32  result / RF data width
//  ADDR_W     5   register index width; scoreboard is 2**ADDR_W bits
//  MEM_FIRST  1   1: MEM source wins the first tie after reset; 0: ALU wins
// PORTS
//  CLK        in   1         clock, all state updates on posedge
//  RSTN       in   1         reset, synchronous, active-low
//  issue_valid in  1         a producer instruction issues this cycle
//  issue_rd   in   ADDR_W    its destination register
//  alu_valid  in   1         ALU result offered
//  alu_ready  out  1         ALU result accepted when valid&ready
//  alu_rd     in   ADDR_W    ALU destination
//  alu_data   in   DATA_W    ALU result
//  mem_valid  in   1         load result offered
//  mem_ready  out  1         load result accepted when valid&ready
//  mem_rd     in   ADDR_W    load destination
//  mem_data   in   DATA_W    load result
//  rf_we      out  1         RF write enable (registered)
//  rf_addr    out  ADDR_W    RF write index (registered)
//  rf_wdata   out  DATA_W    RF write data (registered)
//  pending    out  2**ADDR_W bit r set = write to r in flight (registered)
// BEHAVIOUR
//  Reset: hold_v_alu=hold_v_mem=0, rf_we=0, rf_addr=0, rf_wdata=0,
//   pending=0, last_grant=ALU if MEM_FIRST else MEM. Reset mid-operation
//   discards held results and clears the scoreboard.
//  Per source: one-entry hold register {v, rd, data}.
//  src_ready = ~hold_v | grant_src. It depends only on registered state and
//   never on *_valid. Each source can then sustain one result per cycle.
//  Accept (valid&ready): rd!=0 loads the hold at the edge. rd==0 is consumed
//   and dropped; the hold is not loaded.
//  Arbiter (comb, from holds): only one hold valid -> grant it. Both valid ->
//   grant the source != last_grant (round-robin). last_grant updates on each
//   grant.
//  Granted edge: rf_we<=1, rf_addr<=hold.rd, rf_wdata<=hold.data, the granted
//   hold is freed or reloaded. No grant -> rf_we<=0; addr/data hold value.
//  Latency: handshake at edge T0 -> hold valid; grant at T1 -> rf_we high in
//   cycle T1..T2; RF commits at edge T2. Min 2 edges accept-to-commit.
//  Losing source: its hold is kept and its ready stays low until granted.
//   Worst-case wait is 1 cycle.
//  Scoreboard: at each edge pending[r] is cleared if rf_we&&rf_addr==r.
//   It is set if issue_valid&&issue_rd==r&&r!=0. Set wins over simultaneous
//   clear of the same r. pending[0] is always 0.
//  Upstream guarantees no two in-flight writes to the same rd. This block
//   neither checks nor orders them.
// TESTING
//  1 Reset: RSTN=0 two edges -> rf_we=0, pending=0, alu_ready=mem_ready=1.
//  2 ALU alone: issue rd=5; alu_valid rd=5 data=0xDEADBEEF one cycle ->
//    rf_we=1 addr=5 data=0xDEADBEEF exactly 1 cycle later; pending[5] 1->0.
//  3 Back-to-back ALU rd=1..4, valid held 4 cycles -> 4 consecutive rf_we
//    cycles, addr 1,2,3,4; alu_ready never low.
//  4 Tie after reset (MEM_FIRST=1): alu rd=7/0x11 and mem rd=8/0x22 same
//    cycle -> writes 8 then 7 on consecutive cycles; alu_ready low 1 cycle.
//    Repeat tie -> ALU first.
//  5 rd=0: alu_valid rd=0 data=0xFFFF, issue rd=0 -> accepted, rf_we stays 0,
//    pending stays 0.
//  6 Set/clear race: pending[9]=1; commit rd=9 in the same edge as
//    issue rd=9 -> pending[9]=1 afterwards. RSTN=0 with both holds full ->
//    next cycle rf_we=0, holds empty.

Source files
------------

// File: rtl/rf_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_writeback_arbiter
// Description : Write-side master for the 32x32 register file. Buffers ALU
//               and load results in one-entry holds, round-robins them onto
//               the single RF write port and tracks in-flight destinations
//               in a pending-write scoreboard for decode RAW stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_writeback_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int MEM_FIRST = 1
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  issue_valid,
  input  logic [ADDR_W-1:0]     issue_rd,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_W-1:0]     alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_W-1:0]     mem_rd,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  rf_we,
  output logic [ADDR_W-1:0]     rf_addr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic [2**ADDR_W-1:0]  pending
);

  localparam int          C_NREG    = 2**ADDR_W;
  localparam logic [0:0]  C_SRC_ALU = 1'b0;
  localparam logic [0:0]  C_SRC_MEM = 1'b1;

  // Hold registers, one entry per source
  logic                 r_alu_v;
  logic [ADDR_W-1:0]    r_alu_rd;
  logic [DATA_W-1:0]    r_alu_data;
  logic                 r_mem_v;
  logic [ADDR_W-1:0]    r_mem_rd;
  logic [DATA_W-1:0]    r_mem_data;
  logic [0:0]           r_last_grant;

  // Write port and scoreboard state
  logic                 r_rf_we;
  logic [ADDR_W-1:0]    r_rf_addr;
  logic [DATA_W-1:0]    r_rf_wdata;
  logic [C_NREG-1:0]    r_pending;

  logic                 w_gnt_alu;
  logic                 w_gnt_mem;
  logic                 w_alu_load;
  logic                 w_mem_load;
  logic [C_NREG-1:0]    w_set;
  logic [C_NREG-1:0]    w_clr;
  logic [C_NREG-1:0]    w_pending_nxt;

  // Round-robin grant between the holds; a lone valid hold always wins
  always_comb begin
    w_gnt_alu = r_alu_v & (~r_mem_v | (r_last_grant == C_SRC_MEM));
    w_gnt_mem = r_mem_v & (~r_alu_v | (r_last_grant == C_SRC_ALU));
  end

  // Ready only looks at registered state so producers never see a comb path
  // from their own valid; a granted hold can be refilled in the same cycle.
  assign alu_ready  = ~r_alu_v | w_gnt_alu;
  assign mem_ready  = ~r_mem_v | w_gnt_mem;

  // rd==0 results are swallowed by the handshake and never occupy a hold
  assign w_alu_load = alu_valid & alu_ready & (alu_rd != '0);
  assign w_mem_load = mem_valid & mem_ready & (mem_rd != '0);

  // ALU hold: reload on accepted result, otherwise free once granted
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_alu_v    <= 1'b0;
      r_alu_rd   <= '0;
      r_alu_data <= '0;
    end else if (w_alu_load) begin
      r_alu_v    <= 1'b1;
      r_alu_rd   <= alu_rd;
      r_alu_data <= alu_data;
    end else if (w_gnt_alu) begin
      r_alu_v    <= 1'b0;
    end
  end

  // MEM hold: reload on accepted result, otherwise free once granted
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_mem_v    <= 1'b0;
      r_mem_rd   <= '0;
      r_mem_data <= '0;
    end else if (w_mem_load) begin
      r_mem_v    <= 1'b1;
      r_mem_rd   <= mem_rd;
      r_mem_data <= mem_data;
    end else if (w_gnt_mem) begin
      r_mem_v    <= 1'b0;
    end
  end

  // Remember the last winner; reset value decides who wins the first tie
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_last_grant <= (MEM_FIRST != 0) ? C_SRC_ALU : C_SRC_MEM;
    end else if (w_gnt_alu) begin
      r_last_grant <= C_SRC_ALU;
    end else if (w_gnt_mem) begin
      r_last_grant <= C_SRC_MEM;
    end
  end

  // Register the granted hold onto the RF write port; addr/data hold when idle
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_rf_we    <= 1'b0;
      r_rf_addr  <= '0;
      r_rf_wdata <= '0;
    end else if (w_gnt_alu) begin
      r_rf_we    <= 1'b1;
      r_rf_addr  <= r_alu_rd;
      r_rf_wdata <= r_alu_data;
    end else if (w_gnt_mem) begin
      r_rf_we    <= 1'b1;
      r_rf_addr  <= r_mem_rd;
      r_rf_wdata <= r_mem_data;
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

  // Scoreboard next state: commit clears, issue sets, set beats clear
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (issue_valid && (issue_rd != '0)) begin
      w_set[issue_rd] = 1'b1;
    end
    if (r_rf_we) begin
      w_clr[r_rf_addr] = 1'b1;
    end
    w_pending_nxt    = (r_pending & ~w_clr) | w_set;
    w_pending_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign rf_we    = r_rf_we;
  assign rf_addr  = r_rf_addr;
  assign rf_wdata = r_rf_wdata;
  assign pending  = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_rf_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_writeback_arbiter
// Description : Self-checking bench for rf_writeback_arbiter. Accepted
//               results are queued per source; a monitor matches every RF
//               write against the queue heads and bounds the latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_writeback_arbiter;

  logic        CLK;
  logic        RSTN;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic [31:0] pending;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          acc_edge;
  } exp_t;

  exp_t q_alu[$];
  exp_t q_mem[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   lat;

  rf_writeback_arbiter #(.DATA_W(32), .ADDR_W(5), .MEM_FIRST(1)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .pending(pending)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Edge counter used to timestamp accepts and commits
  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, record accepted results, advance past the edge
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                      input logic iv, input logic [4:0] ird);
    exp_t e;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    issue_valid = iv; issue_rd = ird;
    #1;
    if (RSTN && av && alu_ready && ard != 5'd0) begin
      e.rd = ard; e.data = ad; e.acc_edge = cyc + 1;
      q_alu.push_back(e);
    end
    if (RSTN && mv && mem_ready && mrd != 5'd0) begin
      e.rd = mrd; e.data = md; e.acc_edge = cyc + 1;
      q_mem.push_back(e);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic do_reset(input int n);
    q_alu.delete();
    q_mem.delete();
    RSTN = 1'b0;
    for (int i = 0; i < n; i++) idle();
    RSTN = 1'b1;
  endtask

  // Monitor: every RF write must match the head of one source queue in time
  always @(negedge CLK) begin
    if (rf_we === 1'b1) begin
      checks++;
      if (q_alu.size() > 0 && q_alu[0].rd == rf_addr && q_alu[0].data == rf_wdata) begin
        lat = cyc - q_alu[0].acc_edge;
        void'(q_alu.pop_front());
        if (lat < 1 || lat > 2) begin
          errors++;
          $display("FAIL wr_latency_alu actual=%0d expected=1..2", lat);
        end
      end else if (q_mem.size() > 0 && q_mem[0].rd == rf_addr && q_mem[0].data == rf_wdata) begin
        lat = cyc - q_mem[0].acc_edge;
        void'(q_mem.pop_front());
        if (lat < 1 || lat > 2) begin
          errors++;
          $display("FAIL wr_latency_mem actual=%0d expected=1..2", lat);
        end
      end else begin
        errors++;
        $display("FAIL wr_match actual addr=%0d data=%0h expected a queued ALU/MEM head", rf_addr, rf_wdata);
      end
    end
    if (q_alu.size() > 0 && cyc > q_alu[0].acc_edge + 2) begin
      checks++; errors++;
      $display("FAIL wr_timeout_alu actual=missing expected rd=%0d data=%0h", q_alu[0].rd, q_alu[0].data);
      void'(q_alu.pop_front());
    end
    if (q_mem.size() > 0 && cyc > q_mem[0].acc_edge + 2) begin
      checks++; errors++;
      $display("FAIL wr_timeout_mem actual=missing expected rd=%0d data=%0h", q_mem[0].rd, q_mem[0].data);
      void'(q_mem.pop_front());
    end
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    RSTN = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    issue_valid = 0; issue_rd = 0;
    @(posedge CLK);
    #1;

    // Reset state
    do_reset(2);
    chk("rst_we", rf_we, 0);
    chk("rst_addr", rf_addr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_pending", pending, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_mem_ready", mem_ready, 1);

    // ALU alone with matching issue
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
    chk("alu1_pend_set", pending[5], 1);
    chk("alu1_we_t0", rf_we, 0);
    idle();
    chk("alu1_we", rf_we, 1);
    chk("alu1_addr", rf_addr, 5);
    chk("alu1_data", rf_wdata, 32'hDEADBEEF);
    chk("alu1_pend_hold", pending[5], 1);
    idle();
    chk("alu1_we_off", rf_we, 0);
    chk("alu1_pend_clr", pending[5], 0);

    // Back-to-back ALU results
    for (int i = 1; i <= 4; i++) begin
      chk("b2b_ready", alu_ready, 1);
      step(1'b1, 5'(i), 32'(i * 256), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      if (i >= 2) begin
        chk("b2b_we", rf_we, 1);
        chk("b2b_addr", rf_addr, 5'(i - 1));
      end
    end
    chk("b2b_ready_end", alu_ready, 1);
    idle();
    chk("b2b_we4", rf_we, 1);
    chk("b2b_addr4", rf_addr, 4);
    idle();
    idle();

    // Tie right after reset: MEM first, then round-robin
    do_reset(1);
    step(1'b1, 5'd7, 32'h11, 1'b1, 5'd8, 32'h22, 1'b0, 5'd0);
    chk("tie_alu_ready", alu_ready, 0);
    chk("tie_mem_ready", mem_ready, 1);
    step(1'b1, 5'd10, 32'h33, 1'b1, 5'd11, 32'h44, 1'b0, 5'd0);
    chk("tie_w1_addr", rf_addr, 8);
    chk("tie_w1_data", rf_wdata, 32'h22);
    chk("tie2_alu_ready", alu_ready, 1);
    chk("tie2_mem_ready", mem_ready, 0);
    step(1'b1, 5'd10, 32'h33, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("tie_w2_addr", rf_addr, 7);
    chk("tie_w2_data", rf_wdata, 32'h11);
    idle();
    chk("tie_w3_addr", rf_addr, 11);
    idle();
    chk("tie_w4_addr", rf_addr, 10);
    chk("tie_w4_we", rf_we, 1);
    idle();

    // rd==0 is consumed but never written or tracked
    chk("rd0_ready", alu_ready, 1);
    step(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    chk("rd0_pending", pending, 0);
    idle();
    chk("rd0_we", rf_we, 0);
    chk("rd0_pending2", pending, 0);

    // Set wins over clear on the same register
    step(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    chk("race_set", pending[9], 1);
    idle();
    chk("race_we", rf_we, 1);
    chk("race_addr", rf_addr, 9);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    chk("race_pend", pending[9], 1);

    // Reset with both holds occupied drops them
    step(1'b1, 5'd12, 32'h12, 1'b1, 5'd13, 32'h13, 1'b0, 5'd0);
    chk("full_alu_ready", alu_ready, 0);
    do_reset(1);
    chk("midrst_we", rf_we, 0);
    chk("midrst_pending", pending, 0);
    chk("midrst_alu_ready", alu_ready, 1);
    chk("midrst_mem_ready", mem_ready, 1);
    idle();
    chk("midrst_we2", rf_we, 0);

    // Randomized traffic against the scoreboard
    for (int n = 0; n < 400; n++) begin
      if (q_alu.size() == 0) chk("rnd_alu_idle_ready", alu_ready, 1);
      if (q_mem.size() == 0) chk("rnd_mem_idle_ready", mem_ready, 1);
      step($urandom_range(0, 99) < 60, 5'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 99) < 60, 5'($urandom_range(0, 31)), $urandom,
           1'b0, 5'd0);
    end
    for (int i = 0; i < 4; i++) idle();
    chk("drain_alu", q_alu.size(), 0);
    chk("drain_mem", q_mem.size(), 0);
    chk("drain_we", rf_we, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
